// File: rtl/comb_seq_if.sv
// Bus bundle between the per-sample sequencer and its datapath neighbours.
//   dot_*      : dot-product results from the MAC/adder tree (valid/ready)
//   lbl_*      : label buffer read port (read data one cycle after lbl_rd_en)
//   comb_*     : drive/return of the gradient-scale combinational stage
//   upd_*      : registered result to the weight-update stage (valid/ready)
// master = sequencer side, slave = datapath/environment side.
interface comb_seq_if #(
  parameter int unsigned bitwidth      = 32,
  parameter int unsigned inputBitwidth = 16,
  parameter int unsigned ADDR_W        = 10
);
  logic                     dot_valid;
  logic                     dot_ready;
  logic [bitwidth-1:0]      dot_data;
  logic                     lbl_rd_en;
  logic [ADDR_W-1:0]        lbl_addr;
  logic [inputBitwidth-1:0] lbl_rd_data;
  logic [bitwidth-1:0]      comb_data_in;
  logic [inputBitwidth-1:0] comb_bias;
  logic                     comb_valid;
  logic [bitwidth-1:0]      comb_data_out;
  logic                     upd_valid;
  logic                     upd_ready;
  logic [bitwidth-1:0]      upd_data;

  modport master (
    input  dot_valid, dot_data, lbl_rd_data, comb_data_out, upd_ready,
    output dot_ready, lbl_rd_en, lbl_addr, comb_data_in, comb_bias, comb_valid,
           upd_valid, upd_data
  );

  modport slave (
    output dot_valid, dot_data, lbl_rd_data, comb_data_out, upd_ready,
    input  dot_ready, lbl_rd_en, lbl_addr, comb_data_in, comb_bias, comb_valid,
           upd_valid, upd_data
  );
endinterface

// File: rtl/comb_seq.sv
// Per-sample sequencer for the gradient-scale combinational stage.
// Takes one dot-product result per sample, fetches its label, drives the
// combinational stage for one cycle, and hands the registered result to the
// weight-update stage. Counts samples and pulses done at the end of a batch.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : batch start pulse, only honoured in idle
//   num_samples  : batch length, latched on start
//   lbl_base     : label buffer base address, latched on start
//   busy, done   : status; done is a one-cycle end-of-batch pulse
//   sample_idx   : index of the sample in flight
//   bus          : dot / label / comb-stage / update-stage signals
module comb_seq #(
  parameter int unsigned bitwidth      = 32,
  parameter int unsigned inputBitwidth = 16,
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [ADDR_W-1:0] lbl_base,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_idx,
  comb_seq_if.master        bus
);

  typedef enum logic [2:0] {
    StIdle, StWaitDot, StLbl, StEval, StSend, StDone
  } state_e;

  state_e                   state_q;
  logic [CNT_W-1:0]         num_q;
  logic [CNT_W-1:0]         sample_idx_q;
  logic [ADDR_W-1:0]        lbl_addr_q;
  logic [bitwidth-1:0]      dot_q;
  logic [bitwidth-1:0]      comb_data_in_q;
  logic [inputBitwidth-1:0] comb_bias_q;   // doubles as the label register
  logic [bitwidth-1:0]      result_q;
  logic                     busy_q, done_q, dot_ready_q, comb_valid_q, upd_valid_q;

  logic dot_fire;
  logic last_sample;

  // dot_ready_q is high exactly while waiting for a dot result.
  assign dot_fire    = dot_ready_q & bus.dot_valid;
  assign last_sample = (sample_idx_q == num_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      num_q          <= '0;
      sample_idx_q   <= '0;
      lbl_addr_q     <= '0;
      dot_q          <= '0;
      comb_data_in_q <= '0;
      comb_bias_q    <= '0;
      result_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      dot_ready_q    <= 1'b0;
      comb_valid_q   <= 1'b0;
      upd_valid_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            num_q        <= num_samples;
            lbl_addr_q   <= lbl_base;
            sample_idx_q <= '0;
            busy_q       <= 1'b1;
            if (num_samples == '0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              dot_ready_q <= 1'b1;
              state_q     <= StWaitDot;
            end
          end
        end
        StWaitDot: begin
          if (dot_fire) begin
            dot_q       <= bus.dot_data;
            dot_ready_q <= 1'b0;
            state_q     <= StLbl;
          end
        end
        StLbl: begin
          // Label read issued on the dot handshake lands now.
          comb_data_in_q <= dot_q;
          comb_bias_q    <= bus.lbl_rd_data;
          comb_valid_q   <= 1'b1;
          state_q        <= StEval;
        end
        StEval: begin
          result_q     <= bus.comb_data_out;
          comb_valid_q <= 1'b0;
          upd_valid_q  <= 1'b1;
          state_q      <= StSend;
        end
        StSend: begin
          if (bus.upd_ready) begin
            upd_valid_q <= 1'b0;
            if (last_sample) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              sample_idx_q <= sample_idx_q + CNT_W'(1);
              // Tracks lbl_base + sample_idx, wrapping at 2^ADDR_W.
              lbl_addr_q   <= lbl_addr_q + ADDR_W'(1);
              dot_ready_q  <= 1'b1;
              state_q      <= StWaitDot;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign sample_idx       = sample_idx_q;
  assign bus.dot_ready    = dot_ready_q;
  assign bus.lbl_rd_en    = dot_fire;
  assign bus.lbl_addr     = lbl_addr_q;
  assign bus.comb_data_in = comb_data_in_q;
  assign bus.comb_bias    = comb_bias_q;
  assign bus.comb_valid   = comb_valid_q;
  assign bus.upd_valid    = upd_valid_q;
  assign bus.upd_data     = result_q;

endmodule

// File: tb/tb_comb_seq.sv
// Bench for comb_seq: label buffer and combinational-stage models, a
// scoreboard of expected label addresses, stage operands and update results,
// and one task per scenario.
module tb_comb_seq;
  localparam int unsigned BW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_samples;
  logic [AW-1:0] lbl_base;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_idx;

  comb_seq_if #(.bitwidth(BW), .inputBitwidth(IW), .ADDR_W(AW)) bus ();

  comb_seq #(.bitwidth(BW), .inputBitwidth(IW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .lbl_base    (lbl_base),
    .busy        (busy),
    .done        (done),
    .sample_idx  (sample_idx),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Label buffer: synchronous read, data one cycle after the enable.
  logic [IW-1:0] mem [0:1023];
  always @(posedge clk) if (bus.lbl_rd_en) bus.lbl_rd_data <= mem[bus.lbl_addr];

  // Dot-product source: presents dot_tab[n] for the n-th handshake of a batch.
  logic [BW-1:0] dot_tab [0:15];
  logic [IW-1:0] lbl_tab [0:15];
  int            dot_idx;
  always @(posedge clk) begin
    if (rst || (start && !busy)) dot_idx <= 0;
    else if (bus.dot_valid && bus.dot_ready) dot_idx <= dot_idx + 1;
  end
  assign bus.dot_data = dot_tab[dot_idx[3:0]];

  // Combinational stage model: data_in minus sign-extended bias, masked when idle.
  assign bus.comb_data_out = bus.comb_valid ?
      (bus.comb_data_in - {{16{bus.comb_bias[15]}}, bus.comb_bias}) : '0;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_addr_q [$];
  logic [BW-1:0] exp_in_q   [$];
  logic [IW-1:0] exp_bias_q [$];
  logic [BW-1:0] exp_res_q  [$];

  int r_done_at, r_done_cnt, r_busy_after, r_rden, r_rdy, r_uv, r_stalled;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one batch from start to a few cycles past done, scoreboarding every
  // label read, stage evaluation and update handshake along the way.
  task automatic run_batch(input int n, input logic [AW-1:0] base, input int stall_idx,
                           input int stall_len, input bit busy_start);
    logic [AW-1:0] a;
    logic [BW-1:0] hold_d;
    logic [CW-1:0] hold_i;
    logic [BW-1:0] e_d;
    logic [IW-1:0] e_b;
    logic [AW-1:0] e_a;
    int  k;
    int  stalled;
    bit  finished;
    bit  bs_done;
    for (int i = 0; i < n; i++) begin
      a = base + AW'(i);
      mem[a] = lbl_tab[i];
      exp_addr_q.push_back(a);
      exp_in_q.push_back(dot_tab[i]);
      exp_bias_q.push_back(lbl_tab[i]);
      exp_res_q.push_back(dot_tab[i] - {{16{lbl_tab[i][15]}}, lbl_tab[i]});
    end
    r_done_at = -1; r_done_cnt = 0; r_busy_after = -1;
    r_rden = 0; r_rdy = 0; r_uv = 0;
    stalled = 0; finished = 0; bs_done = 0; k = 0;
    hold_d = '0; hold_i = '0;
    start = 1'b1; num_samples = CW'(n); lbl_base = base;
    while (!finished && k < 300) begin
      tick();
      k++;
      if (k == 1) begin
        num_samples = CW'($urandom);
        lbl_base    = AW'($urandom);
      end
      if (busy_start && !bs_done && bus.upd_valid && sample_idx == 0) begin
        start = 1'b1; num_samples = 9; bs_done = 1;
      end else begin
        start = 1'b0;
      end
      if (stall_len > 0 && bus.upd_valid && sample_idx == CW'(stall_idx)) begin
        if (stalled == 0) begin
          hold_d = bus.upd_data; hold_i = sample_idx;
        end else begin
          checks++;
          if ({bus.upd_valid, bus.upd_data, sample_idx} !== {1'b1, hold_d, hold_i}) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h idx=%0d want v=1 d=%h idx=%0d",
                     bus.upd_valid, bus.upd_data, sample_idx, hold_d, hold_i);
          end
        end
        if (stalled < stall_len) begin
          bus.upd_ready = 1'b0; stalled++;
        end else begin
          bus.upd_ready = 1'b1;
        end
      end else begin
        bus.upd_ready = 1'b1;
      end
      #1;
      if (bus.dot_ready) r_rdy++;
      if (bus.upd_valid) r_uv++;
      if (bus.lbl_rd_en) begin
        r_rden++;
        checks++;
        e_a = exp_addr_q.size() > 0 ? exp_addr_q.pop_front() : 'x;
        if (bus.lbl_addr !== e_a) begin
          errors++;
          $display("FAIL lbl_addr: got %h want %h", bus.lbl_addr, e_a);
        end
      end
      if (bus.comb_valid) begin
        checks++;
        e_d = exp_in_q.size() > 0 ? exp_in_q.pop_front() : 'x;
        e_b = exp_bias_q.size() > 0 ? exp_bias_q.pop_front() : 'x;
        if ({bus.comb_data_in, bus.comb_bias} !== {e_d, e_b}) begin
          errors++;
          $display("FAIL comb_operands: got (%0d,%0d) want (%0d,%0d)",
                   bus.comb_data_in, bus.comb_bias, e_d, e_b);
        end
      end
      if (bus.upd_valid && bus.upd_ready) begin
        checks++;
        e_d = exp_res_q.size() > 0 ? exp_res_q.pop_front() : 'x;
        if (bus.upd_data !== e_d) begin
          errors++;
          $display("FAIL upd_data: got %h want %h", bus.upd_data, e_d);
        end
      end
      if (r_done_at >= 0 && k == r_done_at + 1) r_busy_after = busy;
      if (done) begin
        r_done_cnt++;
        if (r_done_at < 0) r_done_at = k;
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_done: got %b want 1", busy);
        end
      end
      if (r_done_at >= 0 && k >= r_done_at + 3) finished = 1;
    end
    r_stalled = stalled;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL batch_timeout: got no done within %0d cycles want done", k);
    end
    checks++;
    if (exp_res_q.size() != 0 || exp_addr_q.size() != 0 || exp_in_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d results left want 0", exp_res_q.size());
    end
    exp_addr_q.delete(); exp_in_q.delete(); exp_bias_q.delete(); exp_res_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; lbl_base = '0;
    bus.dot_valid = 1'b1; bus.upd_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, bus.dot_ready, bus.lbl_rd_en, bus.comb_valid, bus.upd_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, bus.dot_ready, bus.lbl_rd_en, bus.comb_valid, bus.upd_valid});
    end
    checks++;
    if ({bus.lbl_addr, bus.comb_data_in, bus.comb_bias, bus.upd_data, sample_idx} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h in=%h bias=%h upd=%h idx=%h want all 0",
               bus.lbl_addr, bus.comb_data_in, bus.comb_bias, bus.upd_data, sample_idx);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    dot_tab[0] = 5; dot_tab[1] = 7; dot_tab[2] = 9;
    lbl_tab[0] = 2; lbl_tab[1] = 3; lbl_tab[2] = 4;
    run_batch(3, 10'h010, 0, 0, 0);
    checks++;
    if (r_done_at != 13) begin
      errors++; $display("FAIL basic_done_cycle: got %0d want 13", r_done_at);
    end
    checks++;
    if (r_done_cnt != 1 || r_busy_after != 0) begin
      errors++;
      $display("FAIL basic_done_busy: got done_cnt=%0d busy_after=%0d want 1 and 0",
               r_done_cnt, r_busy_after);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      dot_tab[i] = $urandom; lbl_tab[i] = IW'($urandom);
    end
    run_batch(3, 10'h120, 1, 5, 0);
    checks++;
    if (r_stalled != 5 || r_done_at != 18) begin
      errors++;
      $display("FAIL backpressure: got stalled=%0d done_at=%0d want 5 and 18",
               r_stalled, r_done_at);
    end
  endtask

  task automatic test_empty();
    run_batch(0, 10'h200, 0, 0, 0);
    checks++;
    if (r_done_at != 1 || r_done_cnt != 1) begin
      errors++;
      $display("FAIL empty_done: got done_at=%0d cnt=%0d want 1 and 1", r_done_at, r_done_cnt);
    end
    checks++;
    if (r_rden != 0 || r_rdy != 0 || r_uv != 0) begin
      errors++;
      $display("FAIL empty_quiet: got rden=%0d rdy=%0d uv=%0d want 0 0 0", r_rden, r_rdy, r_uv);
    end
  endtask

  task automatic test_wrap();
    dot_tab[0] = 32'h1234_5678; dot_tab[1] = 32'h0000_0001;
    lbl_tab[0] = 16'h8001;      lbl_tab[1] = 16'h0010;
    run_batch(2, 10'h3FF, 0, 0, 0);
    checks++;
    if (r_rden != 2 || r_done_at != 9) begin
      errors++;
      $display("FAIL wrap_batch: got reads=%0d done_at=%0d want 2 and 9", r_rden, r_done_at);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int quiet_done;
    found = 0; quiet_done = 0;
    for (int i = 0; i < 4; i++) dot_tab[i] = 100 + i;
    start = 1'b1; num_samples = 4; lbl_base = 10'h050;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      start = 1'b0;
      #1;
      if (bus.lbl_rd_en && sample_idx == 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_reach: got no read of sample 1 want one");
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, bus.dot_ready, bus.lbl_rd_en, bus.comb_valid, bus.upd_valid,
         bus.lbl_addr, bus.comb_data_in, bus.comb_bias, bus.upd_data, sample_idx} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got busy=%b v=%b%b%b%b addr=%h in=%h upd=%h idx=%0d want 0",
               busy, bus.dot_ready, bus.lbl_rd_en, bus.comb_valid, bus.upd_valid,
               bus.lbl_addr, bus.comb_data_in, bus.upd_data, sample_idx);
    end
    repeat (6) begin
      tick();
      if (done) quiet_done++;
    end
    checks++;
    if (quiet_done != 0) begin
      errors++; $display("FAIL reset_mid_nodone: got %0d done pulses want 0", quiet_done);
    end
    dot_tab[0] = 32'hFFFF_FFF0; lbl_tab[0] = 16'hFFFE;
    run_batch(1, 10'h060, 0, 0, 0);
    checks++;
    if (r_done_at != 5 || r_done_cnt != 1) begin
      errors++;
      $display("FAIL reset_mid_restart: got done_at=%0d cnt=%0d want 5 and 1",
               r_done_at, r_done_cnt);
    end
  endtask

  task automatic test_start_busy();
    dot_tab[0] = 11; dot_tab[1] = 22;
    lbl_tab[0] = 1;  lbl_tab[1] = 2;
    run_batch(2, 10'h300, 0, 0, 1);
    checks++;
    if (r_done_at != 9 || r_done_cnt != 1 || r_busy_after != 0) begin
      errors++;
      $display("FAIL start_busy: got done_at=%0d cnt=%0d busy_after=%0d want 9 1 0",
               r_done_at, r_done_cnt, r_busy_after);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_wrap();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comb_seq.md
Name: comb_seq

Overview:
- Per-sample sequencer for the gradient-scale combinational stage of the training datapath.
- Accepts dot-product results from the MAC/adder tree over a valid/ready handshake and fetches the matching label from the label buffer.
- Drives the combinational stage (data_in, bias, valid) and forwards its registered result to the weight-update stage over a valid/ready handshake.
- Counts samples per batch and reports done.

Parameters:
- bitwidth, 32, width of dot-product result and combinational-stage data.
- inputBitwidth, 16, width of label (bias) values.
- ADDR_W, 10, label buffer address width.
- CNT_W, 16, sample counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  batch start pulse; sampled only in IDLE.
- num_samples  input  CNT_W  samples in batch; latched on start.
- lbl_base  input  ADDR_W  label buffer base address; latched on start.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at batch end.
- dot_valid  input  1  dot-product result valid.
- dot_ready  output  1  sequencer accepts dot result.
- dot_data  input  bitwidth  dot-product result.
- lbl_rd_en  output  1  label buffer read enable.
- lbl_addr  output  ADDR_W  label buffer read address.
- lbl_rd_data  input  inputBitwidth  label data; valid one cycle after lbl_rd_en.
- comb_data_in  output  bitwidth  to combinational stage data_in.
- comb_bias  output  inputBitwidth  to combinational stage bias.
- comb_valid  output  1  to combinational stage valid.
- comb_data_out  input  bitwidth  result from combinational stage (combinational path).
- upd_valid  output  1  result valid to update stage.
- upd_ready  input  1  update stage accepts result.
- upd_data  output  bitwidth  registered combinational-stage result.
- sample_idx  output  CNT_W  index of the sample currently in flight.

Behaviour:
- Reset: state IDLE; outputs busy, done, dot_ready, lbl_rd_en, comb_valid and upd_valid are 0. Outputs lbl_addr, comb_data_in, comb_bias, upd_data and sample_idx are 0. Internal dot, label, result and count registers are cleared.
- Reset mid-batch: abandons the batch immediately and returns to IDLE. No done pulse. Any captured dot value is discarded.
- FSM states: IDLE, WAIT_DOT, LBL, EVAL, SEND, DONE.
- IDLE:
  - start=1 latches num_samples and lbl_base and clears sample_idx.
  - If num_samples==0, next state is DONE; otherwise WAIT_DOT.
  - start=0 keeps the FSM in IDLE.
- WAIT_DOT:
  - dot_ready=1.
  - On dot_valid&dot_ready: capture dot_data, pulse lbl_rd_en=1 with lbl_addr=(lbl_base+sample_idx) mod 2^ADDR_W, and go to LBL.
  - dot_ready is 0 in every other state.
- LBL: capture lbl_rd_data into the label register; go to EVAL.
- EVAL:
  - comb_valid=1, comb_data_in=dot register, comb_bias=label register.
  - Capture comb_data_out into the result register; go to SEND.
  - In all other states comb_valid=0 and comb_data_in/comb_bias hold their last values, so the stage output is masked to 0.
- SEND:
  - upd_valid=1; upd_data holds stable until the handshake.
  - On upd_ready: if sample_idx==num_samples-1, go to DONE; otherwise increment sample_idx and go to WAIT_DOT.
  - upd_ready=0 stalls indefinitely with no data change.
- DONE: done=1 for exactly one cycle; go to IDLE. busy deasserts in the IDLE cycle that follows.
- Throughput: minimum 4 cycles per sample (WAIT_DOT, LBL, EVAL, SEND) when dot_valid and upd_ready are held high.
- start while busy: ignored; latched parameters do not change.
- Address arithmetic: lbl_base+sample_idx wraps modulo 2^ADDR_W. sample_idx never wraps because the count terminates at num_samples-1.
- upd_ready asserted outside SEND: no effect.

Test Plan:
- Basic batch: rst, then start with num_samples=3, lbl_base=0x010; dot_valid held 1 with dot_data=5,7,9; labels 2,3,4; upd_ready=1.
  - Required: lbl_addr sequence 0x010, 0x011, 0x012.
  - Required: comb_data_in/comb_bias pairs (5,2), (7,3), (9,4); upd_data equals comb_data_out captured in EVAL.
  - Required: done pulses at cycle 13 after start; busy drops the next cycle.
- Backpressure: upd_ready=0 for 5 cycles in SEND.
  - Required: upd_valid stays 1 and upd_data is constant; sample_idx is unchanged until upd_ready=1.
- Empty batch: start with num_samples=0.
  - Required: next cycle done=1; no lbl_rd_en, dot_ready or upd_valid assertion.
- Address wrap: ADDR_W=10, lbl_base=0x3FF, num_samples=2.
  - Required: lbl_addr 0x3FF then 0x000.
- Reset mid-batch: assert rst during LBL of sample 1 of 4.
  - Required: next cycle all outputs are 0 and state is IDLE; no done pulse. A new start with num_samples=1 completes normally.
- Start while busy: pulse start with num_samples=9 during SEND of a 2-sample batch.
  - Required: batch still ends after 2 samples; done asserts once.
